lock_entry_fsm: RTL and testbench

- Controller directly downstream of the 3-bit saturating digit counter; it consumes the counter's index and drives the counter's inc and synchronous clear.
- Compares each keypad digit against the stored combination digit selected by index.
- Opens the lock on a full correct entry and supports reprogramming while open.
- Counts failed attempts and enforces a timed lockout.

---
 rtl/lock_entry_fsm_pkg.sv | 18 +
 rtl/lock_entry_fsm_if.sv | 28 ++
 rtl/lock_entry_fsm_lockout_timer.sv | 29 ++
 rtl/lock_entry_fsm.sv | 136 +++++++++++++
 tb/tb_lock_entry_fsm.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_entry_fsm_pkg.sv
// Shared types and constants for the keypad lock entry controller.
package lock_pkg;

    localparam int IDX_W       = 3;
    localparam int DEF_DIGIT_W = 4;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4,
        OPEN    = 3'd5,
        PCLR    = 3'd6,
        PROG    = 3'd7
    } lock_state_t;

endpackage

// File: rtl/lock_entry_fsm_if.sv
// Keypad, digit-counter and status signals of the lock entry controller.
interface lock_entry_fsm_if
    import lock_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W
);
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               abort;
    logic               lock;
    logic               prog;
    logic [IDX_W-1:0]   index;
    logic               inc;
    logic               cnt_clr;
    logic               unlocked;
    logic               error;
    logic               locked_out;

    modport master (
        output digit_valid, digit, abort, lock, prog, index,
        input  inc, cnt_clr, unlocked, error, locked_out
    );

    modport slave (
        input  digit_valid, digit, abort, lock, prog, index,
        output inc, cnt_clr, unlocked, error, locked_out
    );
endinterface

// File: rtl/lock_entry_fsm_lockout_timer.sv
// Loadable down-counter timing the lockout period; done while the count is zero.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_done
);
    localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(LOCKOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_done = (r_count == '0);
endmodule

// File: rtl/lock_entry_fsm.sv
// Keypad lock controller: digit compare, open/relock, reprogramming and timed lockout.
//   state   | meaning
//   CLEAR   | clear digit counter and mismatch flag
//   ENTRY   | collecting combination digits
//   CHECK   | evaluate mismatch flag
//   FAIL    | error pulse, decide lockout
//   LOCKOUT | all keys ignored until timer expires
//   OPEN    | unlocked, waiting for lock or prog
//   PCLR    | clear digit counter before programming
//   PROG    | writing new combination digits
module lock_entry_fsm
    import lock_pkg::*;
#(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = DEF_DIGIT_W,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                            MAX_FAILS      = 3,
    parameter int                            LOCKOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    lock_entry_fsm_if.slave  bus
);
    localparam int                 FAIL_W   = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0]  MAX_F    = FAIL_W'(MAX_FAILS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CODE_LEN - 1);

    lock_state_t        r_state;
    lock_state_t        w_next;
    logic [DIGIT_W-1:0] r_code [CODE_LEN];
    logic               r_mis;
    logic [FAIL_W-1:0]  r_fails;
    logic               r_cnt_clr;
    logic [DIGIT_W-1:0] w_code_digit;
    logic               w_idx_ok;
    logic               w_digit_mis;
    logic               w_last;
    logic               w_accept;
    logic               w_tmr_load;
    logic               w_tmr_done;

    // An out-of-range index never matches any stored digit.
    always_comb begin
        w_code_digit = '0;
        w_idx_ok     = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (bus.index == IDX_W'(i)) begin
                w_code_digit = r_code[i];
                w_idx_ok     = 1'b1;
            end
        end
    end

    assign w_digit_mis = !w_idx_ok || (bus.digit != w_code_digit);
    assign w_last      = (bus.index == LAST_IDX);
    assign w_accept    = bus.digit_valid && !bus.abort;
    assign w_tmr_load  = (r_state == FAIL) && (r_fails == MAX_F);

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_run  (r_state == LOCKOUT),
        .o_done (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CLEAR:   w_next = ENTRY;
            ENTRY: begin
                if (bus.abort)                   w_next = CLEAR;
                else if (bus.digit_valid && w_last) w_next = CHECK;
            end
            CHECK:   w_next = r_mis ? FAIL : OPEN;
            FAIL:    w_next = (r_fails == MAX_F) ? LOCKOUT : CLEAR;
            LOCKOUT: if (w_tmr_done) w_next = CLEAR;
            OPEN: begin
                if (bus.lock)      w_next = CLEAR;
                else if (bus.prog) w_next = PCLR;
            end
            PCLR:    w_next = PROG;
            PROG: begin
                if (bus.abort)                      w_next = CLEAR;
                else if (bus.digit_valid && w_last) w_next = CLEAR;
            end
            default: w_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                r_code[i] <= DEFAULT_CODE[i*DIGIT_W +: DIGIT_W];
            end
            r_mis     <= 1'b0;
            r_fails   <= '0;
            r_cnt_clr <= 1'b1;
        end else begin
            r_cnt_clr <= (w_next == CLEAR) || (w_next == PCLR);
            case (r_state)
                CLEAR: r_mis <= 1'b0;
                ENTRY: if (w_accept) r_mis <= r_mis | w_digit_mis;
                CHECK: begin
                    if (!r_mis)              r_fails <= '0;
                    else if (r_fails != MAX_F) r_fails <= r_fails + FAIL_W'(1);
                end
                FAIL:  if (r_fails == MAX_F) r_fails <= '0;
                PROG: begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (w_accept && (bus.index == IDX_W'(i))) r_code[i] <= bus.digit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.inc        = bus.digit_valid && ((r_state == ENTRY) || (r_state == PROG));
        bus.cnt_clr    = r_cnt_clr;
        bus.unlocked   = (r_state == OPEN) || (r_state == PCLR) || (r_state == PROG);
        bus.error      = (r_state == FAIL);
        bus.locked_out = (r_state == LOCKOUT);
    end
endmodule

// File: tb/tb_lock_entry_fsm.sv
// Randomised bench for lock_entry_fsm against an entry-level model of the lock.
module tb_lock_entry_fsm;
    import lock_pkg::*;

    localparam int          CODE_LEN       = 4;
    localparam int          DIGIT_W        = 4;
    localparam logic [15:0] DEFAULT_CODE   = 16'h1234;
    localparam int          MAX_FAILS      = 3;
    localparam int          LOCKOUT_CYCLES = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lock_entry_fsm_if #(.DIGIT_W(DIGIT_W)) bus ();

    lock_entry_fsm #(
        .CODE_LEN       (CODE_LEN),
        .DIGIT_W        (DIGIT_W),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Upstream 3-bit saturating digit counter.
    logic [2:0] r_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)                           r_cnt <= 3'd0;
        else if (bus.cnt_clr)               r_cnt <= 3'd0;
        else if (bus.inc && r_cnt != 3'd7)  r_cnt <= r_cnt + 3'd1;
    end
    assign bus.index = r_cnt;

    int m_code [CODE_LEN];
    int m_fails;
    bit m_open;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.digit_valid = 1'b0;
        bus.digit       = '0;
        bus.abort       = 1'b0;
        bus.lock        = 1'b0;
        bus.prog        = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        set_idle();
        #1;
    endtask

    task automatic press(input int d);
        @(negedge clk);
        set_idle();
        bus.digit_valid = 1'b1;
        bus.digit       = d[DIGIT_W-1:0];
        #1;
        check_val("inc", bus.inc, 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'((DEFAULT_CODE >> (DIGIT_W*i)) & 16'hF);
        m_fails = 0;
        m_open  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        #1;
        check_val("rst_unl", bus.unlocked, 0);
        check_val("rst_err", bus.error, 0);
        check_val("rst_lo", bus.locked_out, 0);
        check_val("rst_clr", bus.cnt_clr, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rel_clr", bus.cnt_clr, 1);
        model_reset();
    endtask

    task automatic lockout_wait();
        int  n    = 1;
        bit  done = 1'b0;
        for (int k = 0; k < LOCKOUT_CYCLES + 8 && !done; k++) begin
            @(negedge clk);
            set_idle();
            bus.digit_valid = 1'($urandom_range(0, 1));
            bus.digit       = 4'($urandom);
            #1;
            if (bus.locked_out) begin
                n++;
                if (bus.digit_valid) check_val("lo_inc", bus.inc, 0);
            end else begin
                done = 1'b1;
            end
        end
        check_val("lo_len", n, LOCKOUT_CYCLES);
        check_val("lo_end_clr", bus.cnt_clr, 1);
        check_val("lo_end_inc", bus.inc, 0);
    endtask

    task automatic do_entry(input int seq [CODE_LEN], input bit gaps);
        bit mis = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc();
            press(seq[i]);
            if (seq[i] != m_code[i]) mis = 1'b1;
        end
        cyc();
        check_val("chk_err", bus.error, 0);
        check_val("chk_unl", bus.unlocked, 0);
        check_val("chk_clr", bus.cnt_clr, 0);
        cyc();
        if (!mis) begin
            check_val("open_unl", bus.unlocked, 1);
            check_val("open_err", bus.error, 0);
            m_fails = 0;
            m_open  = 1'b1;
            cyc();
            check_val("open_hold", bus.unlocked, 1);
        end else begin
            check_val("fail_err", bus.error, 1);
            check_val("fail_unl", bus.unlocked, 0);
            m_fails++;
            cyc();
            check_val("err_pulse", bus.error, 0);
            if (m_fails == MAX_FAILS) begin
                m_fails = 0;
                check_val("lo_start", bus.locked_out, 1);
                lockout_wait();
            end else begin
                check_val("fail_clr", bus.cnt_clr, 1);
                check_val("fail_lo", bus.locked_out, 0);
            end
        end
    endtask

    task automatic do_lock(input bit with_prog);
        @(negedge clk);
        set_idle();
        bus.lock = 1'b1;
        bus.prog = with_prog;
        #1;
        check_val("lock_pre", bus.unlocked, 1);
        cyc();
        check_val("lock_clr", bus.cnt_clr, 1);
        check_val("lock_unl", bus.unlocked, 0);
        m_open = 1'b0;
    endtask

    task automatic do_open_idle();
        @(negedge clk);
        set_idle();
        bus.digit_valid = 1'b1;
        bus.digit       = 4'($urandom);
        bus.abort       = 1'($urandom_range(0, 1));
        #1;
        check_val("open_inc", bus.inc, 0);
        check_val("open_idle", bus.unlocked, 1);
    endtask

    task automatic do_abort(input int k, input bit with_dv);
        for (int i = 0; i < k; i++) press($urandom_range(0, 15));
        @(negedge clk);
        set_idle();
        bus.abort       = 1'b1;
        bus.digit_valid = with_dv;
        bus.digit       = 4'($urandom);
        #1;
        cyc();
        check_val("abort_clr", bus.cnt_clr, 1);
        check_val("abort_err", bus.error, 0);
        check_val("abort_unl", bus.unlocked, 0);
    endtask

    task automatic prog_start();
        @(negedge clk);
        set_idle();
        bus.prog = 1'b1;
        #1;
        cyc();
        check_val("pclr_clr", bus.cnt_clr, 1);
        check_val("pclr_unl", bus.unlocked, 1);
    endtask

    task automatic do_prog(input int seq [CODE_LEN], input int n);
        prog_start();
        for (int i = 0; i < n; i++) begin
            press(seq[i]);
            check_val("prog_unl", bus.unlocked, 1);
            m_code[i] = seq[i];
        end
        if (n < CODE_LEN) begin
            @(negedge clk);
            set_idle();
            bus.abort = 1'b1;
            #1;
        end
        cyc();
        check_val("prog_end_clr", bus.cnt_clr, 1);
        check_val("prog_end_unl", bus.unlocked, 0);
        m_open = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [CODE_LEN];
        int r;
        set_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        // Default combination opens, then relock.
        seq = m_code;
        do_entry(seq, 1'b0);
        do_lock(1'b0);

        // Last digit wrong.
        seq = m_code;
        seq[CODE_LEN-1] = seq[CODE_LEN-1] ^ 1;
        do_entry(seq, 1'b0);

        // Clear fail count, then three wrong entries into lockout, then open.
        seq = m_code;
        do_entry(seq, 1'b0);
        do_lock(1'b0);
        for (int a = 0; a < MAX_FAILS; a++) begin
            seq = m_code;
            seq[a % CODE_LEN] = (seq[a % CODE_LEN] + 1) % 16;
            do_entry(seq, 1'b0);
        end
        seq = m_code;
        do_entry(seq, 1'b0);
        do_lock(1'b0);

        // Abort mid-entry.
        do_abort(2, 1'b0);
        seq = m_code;
        do_entry(seq, 1'b0);

        // Reprogram to 9,8,7,6.
        seq = '{9, 8, 7, 6};
        do_prog(seq, CODE_LEN);
        for (int i = 0; i < CODE_LEN; i++) seq[i] = int'((DEFAULT_CODE >> (DIGIT_W*i)) & 16'hF);
        do_entry(seq, 1'b0);
        seq = '{9, 8, 7, 6};
        do_entry(seq, 1'b0);

        // Reset during programming restores the default code.
        prog_start();
        press(1);
        press(1);
        do_reset();
        seq = m_code;
        do_entry(seq, 1'b0);
        do_lock(1'b1);
        seq = m_code;
        do_entry(seq, 1'b0);
        do_lock(1'b0);

        for (int it = 0; it < 80; it++) begin
            if (m_open) begin
                r = $urandom_range(0, 4);
                case (r)
                    0: do_open_idle();
                    1: do_lock(1'b0);
                    2: do_lock(1'b1);
                    default: begin
                        for (int i = 0; i < CODE_LEN; i++) seq[i] = $urandom_range(0, 15);
                        do_prog(seq, (r == 3) ? $urandom_range(1, CODE_LEN) : CODE_LEN);
                    end
                endcase
            end else begin
                r = $urandom_range(0, 4);
                seq = m_code;
                case (r)
                    0, 1: do_entry(seq, 1'b1);
                    2: begin
                        for (int i = 0; i < CODE_LEN; i++) seq[i] = $urandom_range(0, 15);
                        do_entry(seq, 1'b1);
                    end
                    3: do_abort($urandom_range(0, CODE_LEN-1), 1'($urandom_range(0, 1)));
                    default: begin
                        seq[$urandom_range(0, CODE_LEN-1)] ^= $urandom_range(1, 15);
                        do_entry(seq, 1'b1);
                    end
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
